// File: rtl/lsu_mem_stage_if.sv
// Signal bundle for the memory-access stage: upstream beat, data-memory bus and writeback beat.
// The master modport is the stage itself; the slave modport is its surroundings.
interface lsu_mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic [4:0]  rd;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [1:0]  out_exc;

  modport master (
    input  in_valid, opcode, func3, alu_out, store_data, rd,
    input  mem_ack, mem_rdata, out_ready,
    output in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output out_valid, out_data, out_rd, out_wen, out_exc
  );

  modport slave (
    output in_valid, opcode, func3, alu_out, store_data, rd,
    output mem_ack, mem_rdata, out_ready,
    input  in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  out_valid, out_data, out_rd, out_wen, out_exc
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV32I memory-access stage: issues loads/stores over a req/ack bus with lane steering,
// extension, misalignment/illegal-width checks and a bus timeout; emits one registered writeback beat.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst_n,
  lsu_mem_stage_if.master bus
);

  typedef enum logic {IDLE, BUS} state_t;

  localparam logic [4:0] OP_LOAD      = 5'b00000;
  localparam logic [4:0] OP_STORE     = 5'b01000;
  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  state_t      state;
  logic [31:0] tmo_cnt;
  logic        req_load;
  logic [2:0]  req_func3;
  logic [1:0]  req_lane;
  logic [4:0]  req_rd;

  logic        accept;
  logic        is_load;
  logic        is_store;
  logic        func3_bad;
  logic        misaligned;
  logic        tmo_hit;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [15:0] rdata_shift;
  logic [31:0] load_result;

  assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_load      = (bus.opcode == OP_LOAD);
  assign is_store     = (bus.opcode == OP_STORE);
  assign tmo_hit      = (TIMEOUT != 32'd0) && ((tmo_cnt + 32'd1) == TIMEOUT);

  // Width decode of the incoming beat: legality, alignment, lane enables and replicated store data.
  always_comb begin
    func3_bad  = 1'b0;
    misaligned = 1'b0;
    be_next    = 4'b0000;
    wdata_next = 32'h0000_0000;
    if (is_load) begin
      func3_bad = (bus.func3 == 3'b011) || (bus.func3 == 3'b110) || (bus.func3 == 3'b111);
    end else if (is_store) begin
      func3_bad = bus.func3[2] || (bus.func3[1:0] == 2'b11);
    end
    case (bus.func3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << bus.alu_out[1:0];
        wdata_next = {4{bus.store_data[7:0]}};
      end
      2'b01: begin
        misaligned = bus.alu_out[0];
        be_next    = bus.alu_out[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{bus.store_data[15:0]}};
      end
      default: begin
        misaligned = |bus.alu_out[1:0];
        be_next    = 4'b1111;
        wdata_next = bus.store_data;
      end
    endcase
    if (!is_store) begin
      wdata_next = 32'h0000_0000;
    end
  end

  // Halfword accesses are always lane-aligned here, so the byte shift also serves them.
  assign rdata_shift = 16'(bus.mem_rdata >> {req_lane, 3'b000});

  always_comb begin
    load_result = bus.mem_rdata;
    case (req_func3[1:0])
      2'b00:   load_result = {{24{!req_func3[2] && rdata_shift[7]}}, rdata_shift[7:0]};
      2'b01:   load_result = {{16{!req_func3[2] && rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_result = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tmo_cnt       <= 32'd0;
      req_load      <= 1'b0;
      req_func3     <= 3'b000;
      req_lane      <= 2'b00;
      req_rd        <= 5'd0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'h0000_0000;
      bus.mem_be    <= 4'b0000;
      bus.mem_wdata <= 32'h0000_0000;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 32'h0000_0000;
      bus.out_rd    <= 5'd0;
      bus.out_wen   <= 1'b0;
      bus.out_exc   <= EXC_NONE;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_load && !is_store) begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= bus.alu_out;
              bus.out_rd    <= bus.rd;
              bus.out_wen   <= (bus.rd != 5'd0);
              bus.out_exc   <= EXC_NONE;
            end else if (func3_bad || misaligned) begin
              // Rejected accesses report the faulting address and never reach memory.
              bus.out_valid <= 1'b1;
              bus.out_data  <= bus.alu_out;
              bus.out_rd    <= bus.rd;
              bus.out_wen   <= 1'b0;
              bus.out_exc   <= func3_bad ? EXC_ILLEGAL : EXC_MISALIGN;
            end else begin
              state         <= BUS;
              tmo_cnt       <= 32'd0;
              req_load      <= is_load;
              req_func3     <= bus.func3;
              req_lane      <= bus.alu_out[1:0];
              req_rd        <= bus.rd;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= is_store;
              bus.mem_addr  <= {bus.alu_out[31:2], 2'b00};
              bus.mem_be    <= be_next;
              bus.mem_wdata <= wdata_next;
            end
          end
        end
        BUS: begin
          if (bus.mem_ack) begin
            state         <= IDLE;
            tmo_cnt       <= 32'd0;
            bus.mem_req   <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_rd    <= req_rd;
            bus.out_exc   <= EXC_NONE;
            bus.out_data  <= req_load ? load_result : 32'h0000_0000;
            bus.out_wen   <= req_load && (req_rd != 5'd0);
          end else if (tmo_hit) begin
            state         <= IDLE;
            tmo_cnt       <= 32'd0;
            bus.mem_req   <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_rd    <= req_rd;
            bus.out_exc   <= EXC_TIMEOUT;
            bus.out_data  <= 32'h0000_0000;
            bus.out_wen   <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed vector table, hand-written stall/reset
// sequences, then random transactions against a byte-arithmetic reference model.
module tb_lsu_mem_stage;

  localparam int unsigned TMO = 4;
  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] OP_ADD   = 5'b01100;

  typedef struct {
    string       name;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          ack_cycle;
    logic        exp_req;
    int          exp_cycles;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_exc;
    logic        exp_data_chk;
    logic [31:0] exp_data;
    logic        exp_wen;
  } vec_t;

  typedef struct packed {
    logic        hung;
    logic        req_seen;
    logic        unstable;
    logic [31:0] req_cycles;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [1:0]  out_exc;
    logic        in_ready;
  } cap_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];

  lsu_mem_stage_if bus();

  lsu_mem_stage #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void addVec(input string name, input logic [4:0] op, input logic [2:0] f3,
                                 input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                                 input logic [31:0] rdata, input int ack, input logic req, input int cyc,
                                 input logic [31:0] addr, input logic [3:0] be, input logic we,
                                 input logic [31:0] wdata, input logic [1:0] exc, input logic dchk,
                                 input logic [31:0] data, input logic wen);
    vec_t v;
    v.name = name; v.opcode = op; v.func3 = f3; v.alu = alu; v.sd = sd; v.rd = rd;
    v.rdata = rdata; v.ack_cycle = ack; v.exp_req = req; v.exp_cycles = cyc;
    v.exp_addr = addr; v.exp_be = be; v.exp_we = we; v.exp_wdata = wdata;
    v.exp_exc = exc; v.exp_data_chk = dchk; v.exp_data = data; v.exp_wen = wen;
    tbl.push_back(v);
  endfunction

  // Reference model: works in bytes and integer arithmetic rather than bit lanes.
  function automatic vec_t modelTxn(input vec_t v);
    logic   ld;
    logic   st;
    logic   legal;
    int     size_bytes;
    int     off;
    longint span;
    longint val;
    ld = (v.opcode == OP_LOAD);
    st = (v.opcode == OP_STORE);
    v.exp_req = 1'b0; v.exp_cycles = 0; v.exp_addr = 32'h0; v.exp_be = 4'h0;
    v.exp_we = 1'b0; v.exp_wdata = 32'h0; v.exp_exc = 2'b00; v.exp_data_chk = 1'b1;
    if (!ld && !st) begin
      v.exp_data = v.alu;
      v.exp_wen  = (v.rd != 5'd0);
      return v;
    end
    legal = ld ? (v.func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (v.func3 inside {3'd0, 3'd1, 3'd2});
    size_bytes = 1 << int'(v.func3[1:0]);
    off = int'(v.alu[1:0]);
    v.exp_data = v.alu;
    v.exp_wen  = 1'b0;
    if (!legal) begin
      v.exp_exc = 2'b11;
      return v;
    end
    if ((off % size_bytes) != 0) begin
      v.exp_exc = 2'b01;
      return v;
    end
    v.exp_req  = 1'b1;
    v.exp_addr = v.alu - 32'(off);
    v.exp_be   = 4'(((1 << size_bytes) - 1) << off);
    v.exp_we   = st;
    if (st) begin
      if (size_bytes == 1)      v.exp_wdata = v.sd[7:0] * 32'h0101_0101;
      else if (size_bytes == 2) v.exp_wdata = v.sd[15:0] * 32'h0001_0001;
      else                      v.exp_wdata = v.sd;
    end
    if (v.ack_cycle == 0 || v.ack_cycle > int'(TMO)) begin
      v.exp_cycles   = int'(TMO);
      v.exp_exc      = 2'b10;
      v.exp_data_chk = 1'b0;
      return v;
    end
    v.exp_cycles = v.ack_cycle;
    if (st) begin
      v.exp_data = 32'h0;
    end else begin
      span = longint'(1) << (8 * size_bytes);
      val  = (longint'(v.rdata) >> (8 * off)) % span;
      if (!v.func3[2] && size_bytes < 4 && val >= span / 2) val = val - span;
      v.exp_data = val[31:0];
      v.exp_wen  = (v.rd != 5'd0);
    end
    return v;
  endfunction

  task automatic waitReady(input string name);
    int budget = 0;
    while (!bus.in_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Presents one beat, plays memory for it, and captures the resulting writeback beat.
  task automatic applyStimulus(input vec_t v, output cap_t c);
    int budget = 0;
    c = '0;
    bus.opcode = v.opcode; bus.func3 = v.func3; bus.alu_out = v.alu;
    bus.store_data = v.sd; bus.rd = v.rd; bus.in_valid = 1'b1;
    while (!bus.in_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!bus.in_ready) begin
      c.hung = 1'b1;
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    budget = 0;
    while (bus.mem_req && budget < 400) begin
      if (!c.req_seen) begin
        c.req_seen = 1'b1;
        c.addr = bus.mem_addr; c.be = bus.mem_be; c.we = bus.mem_we; c.wdata = bus.mem_wdata;
      end else if (bus.mem_addr !== c.addr || bus.mem_be !== c.be ||
                   bus.mem_we !== c.we || bus.mem_wdata !== c.wdata) begin
        c.unstable = 1'b1;
      end
      c.req_cycles = c.req_cycles + 32'd1;
      bus.mem_ack   = (int'(c.req_cycles) == v.ack_cycle);
      bus.mem_rdata = bus.mem_ack ? v.rdata : $urandom;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      budget++;
    end
    if (bus.mem_req) c.hung = 1'b1;
    c.out_valid = bus.out_valid; c.out_data = bus.out_data; c.out_rd = bus.out_rd;
    c.out_wen = bus.out_wen; c.out_exc = bus.out_exc; c.in_ready = bus.in_ready;
  endtask

  task automatic checkTxn(input vec_t v, input cap_t c);
    checkOutput({v.name, " hang"}, 32'(c.hung), 32'd0);
    if (c.hung) return;
    checkOutput({v.name, " mem_req"}, 32'(c.req_seen), 32'(v.exp_req));
    if (v.exp_req) begin
      checkOutput({v.name, " mem_addr"}, c.addr, v.exp_addr);
      checkOutput({v.name, " mem_be"}, 32'(c.be), 32'(v.exp_be));
      checkOutput({v.name, " mem_we"}, 32'(c.we), 32'(v.exp_we));
      checkOutput({v.name, " mem_wdata"}, c.wdata, v.exp_wdata);
      checkOutput({v.name, " req_cycles"}, c.req_cycles, 32'(v.exp_cycles));
      checkOutput({v.name, " bus_stable"}, 32'(c.unstable), 32'd0);
    end
    checkOutput({v.name, " out_valid"}, 32'(c.out_valid), 32'd1);
    checkOutput({v.name, " out_exc"}, 32'(c.out_exc), 32'(v.exp_exc));
    checkOutput({v.name, " out_wen"}, 32'(c.out_wen), 32'(v.exp_wen));
    if (v.exp_data_chk) checkOutput({v.name, " out_data"}, c.out_data, v.exp_data);
    if (v.exp_exc == 2'b00) checkOutput({v.name, " out_rd"}, 32'(c.out_rd), 32'(v.rd));
    checkOutput({v.name, " in_ready_after"}, 32'(c.in_ready), 32'd1);
  endtask

  initial begin
    cap_t c;
    vec_t v;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.opcode = 5'd0; bus.func3 = 3'd0; bus.alu_out = 32'h0;
    bus.store_data = 32'h0; bus.rd = 5'd0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    bus.out_ready = 1'b1;

    addVec("add",       OP_ADD,   3'b000, 32'h0000_1234, 32'h0,         5'd5, 32'h0,         0, 1'b0, 0, 32'h0,   4'b0000, 1'b0, 32'h0,         2'b00, 1'b1, 32'h0000_1234, 1'b1);
    addVec("add_rd0",   OP_ADD,   3'b000, 32'h0000_5678, 32'h0,         5'd0, 32'h0,         0, 1'b0, 0, 32'h0,   4'b0000, 1'b0, 32'h0,         2'b00, 1'b1, 32'h0000_5678, 1'b0);
    addVec("lb",        OP_LOAD,  3'b000, 32'h0000_0103, 32'h0,         5'd9, 32'h80FF_1122, 3, 1'b1, 3, 32'h100, 4'b1000, 1'b0, 32'h0,         2'b00, 1'b1, 32'hFFFF_FF80, 1'b1);
    addVec("lbu",       OP_LOAD,  3'b100, 32'h0000_0103, 32'h0,         5'd9, 32'h80FF_1122, 3, 1'b1, 3, 32'h100, 4'b1000, 1'b0, 32'h0,         2'b00, 1'b1, 32'h0000_0080, 1'b1);
    addVec("lb_pos",    OP_LOAD,  3'b000, 32'h0000_0101, 32'h0,         5'd8, 32'h80FF_1122, 2, 1'b1, 2, 32'h100, 4'b0010, 1'b0, 32'h0,         2'b00, 1'b1, 32'h0000_0011, 1'b1);
    addVec("lh",        OP_LOAD,  3'b001, 32'h0000_0102, 32'h0,         5'd6, 32'h80FF_1122, 1, 1'b1, 1, 32'h100, 4'b1100, 1'b0, 32'h0,         2'b00, 1'b1, 32'hFFFF_80FF, 1'b1);
    addVec("lhu",       OP_LOAD,  3'b101, 32'h0000_0102, 32'h0,         5'd6, 32'h80FF_1122, 1, 1'b1, 1, 32'h100, 4'b1100, 1'b0, 32'h0,         2'b00, 1'b1, 32'h0000_80FF, 1'b1);
    addVec("lw_rd0",    OP_LOAD,  3'b010, 32'h0000_0100, 32'h0,         5'd0, 32'h80FF_1122, 1, 1'b1, 1, 32'h100, 4'b1111, 1'b0, 32'h0,         2'b00, 1'b1, 32'h80FF_1122, 1'b0);
    addVec("sh",        OP_STORE, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 5'd3, 32'h0,         2, 1'b1, 2, 32'h200, 4'b1100, 1'b1, 32'hBEEF_BEEF, 2'b00, 1'b1, 32'h0,         1'b0);
    addVec("sb",        OP_STORE, 3'b000, 32'h0000_0101, 32'h1234_5678, 5'd1, 32'h0,         1, 1'b1, 1, 32'h100, 4'b0010, 1'b1, 32'h7878_7878, 2'b00, 1'b1, 32'h0,         1'b0);
    addVec("sw",        OP_STORE, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 5'd1, 32'h0,         2, 1'b1, 2, 32'h300, 4'b1111, 1'b1, 32'hCAFE_F00D, 2'b00, 1'b1, 32'h0,         1'b0);
    addVec("lw_mis",    OP_LOAD,  3'b010, 32'h0000_0201, 32'h0,         5'd4, 32'h0,         0, 1'b0, 0, 32'h0,   4'b0000, 1'b0, 32'h0,         2'b01, 1'b1, 32'h0000_0201, 1'b0);
    addVec("lh_mis",    OP_LOAD,  3'b001, 32'h0000_0101, 32'h0,         5'd4, 32'h0,         0, 1'b0, 0, 32'h0,   4'b0000, 1'b0, 32'h0,         2'b01, 1'b1, 32'h0000_0101, 1'b0);
    addVec("ld_f3_011", OP_LOAD,  3'b011, 32'h0000_0100, 32'h0,         5'd4, 32'h0,         0, 1'b0, 0, 32'h0,   4'b0000, 1'b0, 32'h0,         2'b11, 1'b1, 32'h0000_0100, 1'b0);
    addVec("st_f3_100", OP_STORE, 3'b100, 32'h0000_0300, 32'h0,         5'd4, 32'h0,         0, 1'b0, 0, 32'h0,   4'b0000, 1'b0, 32'h0,         2'b11, 1'b1, 32'h0000_0300, 1'b0);
    addVec("lw_tmo",    OP_LOAD,  3'b010, 32'h0000_0400, 32'h0,         5'd7, 32'h0,         0, 1'b1, 4, 32'h400, 4'b1111, 1'b0, 32'h0,         2'b10, 1'b0, 32'h0,         1'b0);
    addVec("lw_ack4",   OP_LOAD,  3'b010, 32'h0000_0400, 32'h0,         5'd2, 32'h1122_3344, 4, 1'b1, 4, 32'h400, 4'b1111, 1'b0, 32'h0,         2'b00, 1'b1, 32'h1122_3344, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("reset mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("reset mem_be", 32'(bus.mem_be), 32'd0);
    checkOutput("reset mem_addr", bus.mem_addr, 32'd0);
    checkOutput("reset mem_wdata", bus.mem_wdata, 32'd0);
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset out_data", bus.out_data, 32'd0);
    checkOutput("reset out_rd", 32'(bus.out_rd), 32'd0);
    checkOutput("reset out_wen", 32'(bus.out_wen), 32'd0);
    checkOutput("reset out_exc", 32'(bus.out_exc), 32'd0);
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vectors: %0d", tbl.size());
    foreach (tbl[i]) begin
      applyStimulus(tbl[i], c);
      checkTxn(tbl[i], c);
    end

    // Back-pressure: a stalled beat holds and blocks a waiting beat, which loads on the handshake edge.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.opcode = OP_ADD; bus.func3 = 3'b000; bus.alu_out = 32'h0000_ABCD; bus.rd = 5'd7;
    bus.in_valid = 1'b1;
    waitReady("stall first");
    @(posedge clk); #1;
    bus.alu_out = 32'h0000_BEEF; bus.rd = 5'd8;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("stall out_data", bus.out_data, 32'h0000_ABCD);
      checkOutput("stall out_rd", 32'(bus.out_rd), 32'd7);
      checkOutput("stall out_wen", 32'(bus.out_wen), 32'd1);
      checkOutput("stall in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput("stall release out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("stall release out_data", bus.out_data, 32'h0000_BEEF);
    checkOutput("stall release out_rd", 32'(bus.out_rd), 32'd8);
    @(posedge clk); #1;
    checkOutput("stall drained out_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-request, followed by a stray ack once reset is released.
    bus.opcode = OP_LOAD; bus.func3 = 3'b010; bus.alu_out = 32'h0000_0500; bus.rd = 5'd3;
    bus.in_valid = 1'b1;
    waitReady("rst_bus");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput("rst_bus mem_req_before", 32'(bus.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_bus mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("rst_bus out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    checkOutput("late_ack out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("late_ack mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("late_ack in_ready", 32'(bus.in_ready), 32'd1);

    for (int n = 0; n < 80; n++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      v.name = $sformatf("rand%0d", n);
      if (sel == 0)      v.opcode = OP_LOAD;
      else if (sel == 1) v.opcode = OP_STORE;
      else begin
        v.opcode = 5'($urandom_range(0, 31));
        if (v.opcode == OP_LOAD || v.opcode == OP_STORE) v.opcode = OP_ADD;
      end
      v.func3 = 3'($urandom_range(0, 7));
      v.alu = $urandom;
      v.sd = $urandom;
      v.rd = 5'($urandom_range(0, 31));
      v.rdata = $urandom;
      v.ack_cycle = int'($urandom_range(0, 6));
      v = modelTxn(v);
      applyStimulus(v, c);
      checkTxn(v, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Memory-access stage directly downstream of the ALU in the RV32I core. It consumes the ALU result together with opcode/func3, the store operand and the destination register. Loads and stores are issued to data memory over a req/ack handshake, with byte-lane steering, sign/zero extension, misalignment detection and a bus timeout. The stage presents a single registered writeback beat to the writeback stage using a valid/ready handshake.

Parameters:
TIMEOUT, 255, maximum number of cycles mem_req may stay high without mem_ack; 0 disables the timeout.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
opcode  in  5  instruction opcode[6:2]; 00000 = load, 01000 = store, anything else = non-memory
func3  in  3  width/sign selector
alu_out  in  32  effective address for load/store; final writeback value for all other ops
store_data  in  32  rs2 value for stores
rd  in  5  destination register
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  memory completion; mem_rdata is valid in the ack cycle
mem_rdata  in  32  read word
out_valid  out  1  writeback beat valid
out_ready  in  1  writeback accepts the beat
out_data  out  32  writeback value
out_rd  out  5  destination register
out_wen  out  1  register write enable
out_exc  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal func3

Behaviour:
- Reset: state IDLE. mem_req, mem_we, mem_be, mem_addr, mem_wdata, out_valid, out_data, out_rd, out_wen, out_exc and the timeout counter are all 0.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A beat is accepted when in_valid && in_ready.
- States:
  - IDLE: waits for an accepted beat.
  - BUS: mem_req held high.
  - DONE is expressed only by out_valid; there is no separate state.
- Non-memory op accepted:
  - Next cycle: out_valid=1, out_data=alu_out, out_rd=rd, out_wen=(rd!=0), out_exc=00.
  - Latency 1; stays in IDLE.
- Load/store accepted, legality checks:
  - Illegal func3: loads 011/110/111, stores >=011. Next cycle: out_valid=1, out_exc=11, out_wen=0, out_data=alu_out. No memory request.
  - Misaligned: H accesses with addr[0]=1; W accesses with addr[1:0]!=0. Next cycle: out_valid=1, out_exc=01, out_wen=0, out_data=alu_out. No memory request.
- Legal load/store:
  - Next cycle: mem_req=1 and state BUS.
  - mem_addr, mem_we, mem_be and mem_wdata are registered at acceptance and stay stable until the request ends.
- Byte enables: B: 4'b0001<<addr[1:0]. H: addr[1]?1100:0011. W: 1111.
- Write data: SB replicates store_data[7:0] ×4; SH replicates [15:0] ×2; SW passes it through. Loads drive mem_we=0 and mem_wdata=0.
- BUS state:
  - Counter increments each cycle while mem_req=1.
  - mem_ack in cycle N: mem_req=0 in N+1, out_valid=1 in N+1, state IDLE.
  - Load result: selected lane of mem_rdata. LB/LH are sign-extended, LBU/LHU zero-extended, LW passed through. out_wen=(rd!=0).
  - Store result: out_wen=0, out_data=0.
- Timeout: if TIMEOUT!=0 and the counter reaches TIMEOUT without ack, next cycle: mem_req=0, out_valid=1, out_exc=10, out_wen=0, state IDLE. mem_ack in that same cycle wins over the timeout.
- mem_ack while mem_req=0 is ignored.
- The output beat holds all out_* fields stable while out_valid && !out_ready. out_valid clears after handshake unless a new beat loads in the same cycle.
- Asynchronous reset in any state drops mem_req immediately and discards the pending beat. A late ack after reset release is ignored.

Test Plan:
- ADD result: alu_out=0x0000_1234, rd=5, opcode=01100, out_ready=1 -> one cycle later out_valid=1, out_data=0x1234, out_wen=1. A second beat with rd=0 gives out_wen=0.
- LB, addr 0x103, mem_rdata=0x80FF_1122, ack 3 cycles after mem_req -> mem_addr=0x100, mem_be=1000, mem_we=0. Cycle after ack: out_data=0xFFFF_FF80. The same access as LBU gives 0x0000_0080.
- SH, addr 0x202, store_data=0xDEAD_BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF. Result: out_valid=1, out_wen=0.
- LW at 0x201 -> no mem_req; next cycle out_exc=01, out_data=0x201. Load func3=011 -> out_exc=11.
- TIMEOUT=4, mem_ack tied low -> mem_req high for exactly 4 cycles, then out_exc=10 and in_ready returns high. Ack in the 4th cycle -> normal completion, out_exc=00.
- out_ready=0 for 5 cycles with out_valid=1 -> out_* fields stable, in_ready=0. Reset asserted during BUS -> mem_req=0 and out_valid=0 immediately.
